// File: rtl/ptr_stream_fifo_pkg.sv
// Shared pointer definitions for the pointer-sequence generator and its downstream FIFO.
// Pointer 0 is the null node and is never a legal stream element.
package ptr_stream_fifo_pkg;

  localparam int unsigned n     = 16;
  localparam int unsigned Width = $clog2(n);

  typedef logic [Width-1:0] Pointer;

  function automatic logic is_null(input Pointer p);
    return (p == '0);
  endfunction

endpackage

// File: rtl/ptr_fifo_mem.sv
// Depth x Width register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module ptr_fifo_mem
  import ptr_stream_fifo_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_wa,
  input  Pointer           i_wd,
  input  logic [AddrW-1:0] i_ra,
  output Pointer           o_rd
);

  Pointer r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd = r_mem[i_ra];

endmodule

// File: rtl/ptr_stream_fifo.sv
// Elastic buffer turning the generator's valid-only pointer stream into a valid/ready stream,
// with occupancy, saturating overflow-drop count and a sticky null-pointer error flag.
module ptr_stream_fifo
  import ptr_stream_fifo_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned AddrW  = $clog2(Depth),
  localparam int unsigned CountW = $clog2(Depth + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  Pointer            i_in_ptr,
  input  logic              i_in_vld,
  output Pointer            o_out_ptr,
  output logic              o_out_vld,
  input  logic              i_out_rdy,
  output logic [CountW-1:0] o_count,
  output logic              o_full,
  output logic [7:0]        o_drop_cnt,
  output logic              o_err
);

  logic [AddrW-1:0]  r_wp;
  logic [AddrW-1:0]  r_rp;
  logic [CountW-1:0] r_count;
  logic [7:0]        r_drop_cnt;
  logic              r_err;

  logic              w_in_good;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_overflow;
  logic [CountW-1:0] w_count_next;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CountW'(Depth));
  assign w_in_good = i_in_vld && !is_null(i_in_ptr);

  assign w_pop      = !w_empty && i_out_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push     = w_in_good && (!w_full || w_pop);
  assign w_overflow = w_in_good && w_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CountW'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CountW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AddrW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AddrW'(1);
      end
      r_count <= w_count_next;
      if (w_overflow && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (i_in_vld && is_null(i_in_ptr)) begin
        r_err <= 1'b1;
      end
    end
  end

  ptr_fifo_mem #(
    .Depth (Depth)
  ) u_mem (
    .i_clk (i_clk),
    .i_we  (w_push),
    .i_wa  (r_wp),
    .i_wd  (i_in_ptr),
    .i_ra  (r_rp),
    .o_rd  (o_out_ptr)
  );

  assign o_out_vld  = !w_empty;
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_drop_cnt = r_drop_cnt;
  assign o_err      = r_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (r_count <= CountW'(Depth))
        else $error("occupancy above Depth");
    end
  end

endmodule

// File: tb/tb_ptr_stream_fifo.sv
// Directed self-checking bench for ptr_stream_fifo (Depth = 8).
module tb_ptr_stream_fifo;
  import ptr_stream_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  Pointer     in_ptr;
  logic       in_vld;
  Pointer     out_ptr;
  logic       out_vld;
  logic       out_rdy;
  logic [3:0] count;
  logic       full;
  logic [7:0] drop_cnt;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ptr_stream_fifo #(
    .Depth (8)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_ptr   (in_ptr),
    .i_in_vld   (in_vld),
    .o_out_ptr  (out_ptr),
    .o_out_vld  (out_vld),
    .i_out_rdy  (out_rdy),
    .o_count    (count),
    .o_full     (full),
    .o_drop_cnt (drop_cnt),
    .o_err      (err)
  );

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_vld = 1'b0; in_ptr = '0; out_rdy = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b1; in_ptr = 4'd5; out_rdy = 1'b0;
    tick();
    rst = 1'b0; in_vld = 1'b0;
    n_checks++; if (count !== 4'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_checks++; if (out_vld !== 1'b0) $display("FAIL reset_out_vld got %b want 0", out_vld); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop got %0d want 0", drop_cnt); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
  endtask

  task automatic test_single();
    in_ptr = 4'd7; in_vld = 1'b1; out_rdy = 1'b1;
    tick();
    in_vld = 1'b0;
    n_checks++; if (out_vld !== 1'b1) $display("FAIL single_vld got %b want 1", out_vld); else n_pass++;
    n_checks++; if (out_ptr !== 4'd7) $display("FAIL single_ptr got %0d want 7", out_ptr); else n_pass++;
    n_checks++; if (count !== 4'd1) $display("FAIL single_count1 got %0d want 1", count); else n_pass++;
    tick();
    n_checks++; if (out_vld !== 1'b0) $display("FAIL single_empty got %b want 0", out_vld); else n_pass++;
    n_checks++; if (count !== 4'd0) $display("FAIL single_count0 got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_burst_stall();
    Pointer exp_b [3];
    exp_b[0] = 4'd7; exp_b[1] = 4'd15; exp_b[2] = 4'd8;
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_ptr = exp_b[i]; in_vld = 1'b1;
      tick();
    end
    in_vld = 1'b0;
    n_checks++; if (count !== 4'd3) $display("FAIL burst_count got %0d want 3", count); else n_pass++;
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_vld !== 1'b1 || out_ptr !== exp_b[i])
        $display("FAIL burst_out%0d got vld=%b ptr=%0d want vld=1 ptr=%0d", i, out_vld, out_ptr, exp_b[i]);
      else n_pass++;
      tick();
    end
    out_rdy = 1'b0;
    n_checks++; if (count !== 4'd0) $display("FAIL burst_drained got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_rdy = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      in_ptr = Pointer'(k); in_vld = 1'b1;
      tick();
      n_checks++;
      if (out_vld !== 1'b1 || out_ptr !== Pointer'(k) || count !== 4'd1)
        $display("FAIL b2b_%0d got vld=%b ptr=%0d count=%0d want vld=1 ptr=%0d count=1",
                 k, out_vld, out_ptr, count, k);
      else n_pass++;
    end
    in_vld = 1'b0;
    tick();
    out_rdy = 1'b0;
    n_checks++; if (count !== 4'd0) $display("FAIL b2b_end got %0d want 0", count); else n_pass++;
  endtask

  // Leaves the FIFO holding 2..8,9 after the full push/pop, then drains it.
  task automatic test_overflow_and_full_push_pop();
    do_reset();
    out_rdy = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      in_ptr = Pointer'(k); in_vld = 1'b1;
      tick();
    end
    in_vld = 1'b0;
    n_checks++; if (full !== 1'b1) $display("FAIL ovf_full got %b want 1", full); else n_pass++;
    n_checks++; if (count !== 4'd8) $display("FAIL ovf_count got %0d want 8", count); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd2) $display("FAIL ovf_drop got %0d want 2", drop_cnt); else n_pass++;
    n_checks++; if (out_ptr !== 4'd1) $display("FAIL ovf_head got %0d want 1", out_ptr); else n_pass++;

    in_ptr = 4'd9; in_vld = 1'b1; out_rdy = 1'b1;
    tick();
    in_vld = 1'b0;
    n_checks++; if (count !== 4'd8) $display("FAIL fpp_count got %0d want 8", count); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd2) $display("FAIL fpp_drop got %0d want 2", drop_cnt); else n_pass++;
    n_checks++; if (full !== 1'b1) $display("FAIL fpp_full got %b want 1", full); else n_pass++;

    for (int k = 2; k <= 9; k++) begin
      n_checks++;
      if (out_vld !== 1'b1 || out_ptr !== Pointer'(k))
        $display("FAIL drain_%0d got vld=%b ptr=%0d want vld=1 ptr=%0d", k, out_vld, out_ptr, k);
      else n_pass++;
      tick();
    end
    out_rdy = 1'b0;
    n_checks++; if (out_vld !== 1'b0) $display("FAIL drain_empty got %b want 0", out_vld); else n_pass++;
  endtask

  task automatic test_null();
    out_rdy = 1'b0;
    in_ptr = 4'd3; in_vld = 1'b1;
    tick();
    in_ptr = 4'd0; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    n_checks++; if (err !== 1'b1) $display("FAIL null_err got %b want 1", err); else n_pass++;
    n_checks++; if (count !== 4'd1) $display("FAIL null_count got %0d want 1", count); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd2) $display("FAIL null_drop got %0d want 2", drop_cnt); else n_pass++;
    tick();
    tick();
    n_checks++; if (err !== 1'b1) $display("FAIL null_sticky got %b want 1", err); else n_pass++;
    n_checks++; if (out_ptr !== 4'd3) $display("FAIL null_head got %0d want 3", out_ptr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_rdy = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      in_ptr = Pointer'(k); in_vld = 1'b1;
      tick();
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    tick(); tick(); tick();
    out_rdy = 1'b0;
    in_ptr = 4'd0; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    n_checks++;
    if (count !== 4'd5 || drop_cnt !== 8'd3 || err !== 1'b1)
      $display("FAIL mid_pre got count=%0d drop=%0d err=%b want count=5 drop=3 err=1",
               count, drop_cnt, err);
    else n_pass++;
    rst = 1'b1; in_ptr = 4'd6; in_vld = 1'b1;
    tick();
    rst = 1'b0; in_vld = 1'b0;
    n_checks++; if (count !== 4'd0) $display("FAIL mid_count got %0d want 0", count); else n_pass++;
    n_checks++; if (out_vld !== 1'b0) $display("FAIL mid_vld got %b want 0", out_vld); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL mid_drop got %0d want 0", drop_cnt); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL mid_err got %b want 0", err); else n_pass++;
    tick();
    n_checks++; if (count !== 4'd0) $display("FAIL mid_after got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_drop_saturation();
    do_reset();
    out_rdy = 1'b0;
    for (int i = 0; i < 268; i++) begin
      in_ptr = Pointer'((i % 15) + 1); in_vld = 1'b1;
      tick();
    end
    in_vld = 1'b0;
    n_checks++; if (drop_cnt !== 8'd255) $display("FAIL sat_drop got %0d want 255", drop_cnt); else n_pass++;
    n_checks++; if (count !== 4'd8) $display("FAIL sat_count got %0d want 8", count); else n_pass++;
    n_checks++; if (out_ptr !== 4'd1) $display("FAIL sat_head got %0d want 1", out_ptr); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_ptr = '0; out_rdy = 1'b0;
    #1;
    test_reset();
    test_single();
    test_burst_stall();
    test_back_to_back();
    test_overflow_and_full_push_pop();
    test_null();
    test_reset_mid();
    test_drop_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
